reg_file_ctrl: RTL

Access controller for the 2-read/1-write register file. It clears every register after reset. It then shares the register-file ports between two requesters, core pipeline (c_) and debug port (d_), issuing at most one operation per cycle. A debug lock lets the debug port take exclusive ownership while the core is halted.

---
 rtl/reg_file_ctrl_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/reg_file_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and helpers for the register-file access controller.
package reg_file_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic {
    CORE  = 1'b0,
    DEBUG = 1'b1
  } owner_t;

  // True when the address falls inside the attached register file.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; lock hands the port to the debug requester only.
module rr_arb2
  import reg_file_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_t rr_next;

  always_comb begin
    gnt = 2'b00;
    if (lock) begin
      gnt[1] = req[1];
    end else if (req == 2'b11) begin
      gnt = (rr_next == CORE) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Any unlocked grant, contested or not, hands priority to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_next <= CORE;
    end else if (advance && !lock && (gnt != 2'b00)) begin
      rr_next <= gnt[0] ? DEBUG : CORE;
    end
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file access controller: clear sweep after reset, then core/debug sharing
// of the 2-read/1-write port with a one-cycle read-return pipeline.
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 12,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [ADDR_W-1:0]    c_addr_a,
  input  logic [ADDR_W-1:0]    c_addr_b,
  input  logic [REG_WIDTH-1:0] c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [REG_WIDTH-1:0] c_rdata_a,
  output logic [REG_WIDTH-1:0] c_rdata_b,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr_a,
  input  logic [ADDR_W-1:0]    d_addr_b,
  input  logic [REG_WIDTH-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [REG_WIDTH-1:0] d_rdata_a,
  output logic [REG_WIDTH-1:0] d_rdata_b,
  input  logic                 dbg_lock,
  output logic                 init_done,
  output logic                 rf_read,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_rt_addr,
  output logic [ADDR_W-1:0]    rf_rs_addr,
  output logic [ADDR_W-1:0]    rf_rd_addr,
  output logic [REG_WIDTH-1:0] rf_rd_in,
  input  logic [REG_WIDTH-1:0] rf_rt_out,
  input  logic [REG_WIDTH-1:0] rf_rs_out
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    init_ptr;
  logic [1:0]           req, gnt;
  logic                 issue_we;
  logic [ADDR_W-1:0]    issue_a, issue_b;
  logic [REG_WIDTH-1:0] issue_wd;
  logic                 vld_p1;
  owner_t               owner_p1;
  logic                 ok_a_p1, ok_b_p1;
  logic [REG_WIDTH-1:0] lane_a, lane_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_ptr <= (init_ptr == LAST_REG) ? '0 : init_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_ptr == LAST_REG) state_nxt = RUN;
      RUN:     if (dbg_lock) state_nxt = LOCKED;
      LOCKED:  if (!dbg_lock) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign init_done = (state != INIT);
  assign req       = (state == INIT) ? 2'b00 : {d_req, c_req};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (state == LOCKED),
    .advance (state == RUN),
    .gnt     (gnt)
  );

  assign c_gnt = gnt[0];
  assign d_gnt = gnt[1];

  assign issue_we = gnt[1] ? d_we     : c_we;
  assign issue_a  = gnt[1] ? d_addr_a : c_addr_a;
  assign issue_b  = gnt[1] ? d_addr_b : c_addr_b;
  assign issue_wd = gnt[1] ? d_wdata  : c_wdata;

  // Stage p0: drive the register-file port (sweep write, granted write, or read pair).
  always_comb begin
    rf_read    = 1'b0;
    rf_write   = 1'b0;
    rf_rt_addr = '0;
    rf_rs_addr = '0;
    rf_rd_addr = '0;
    rf_rd_in   = '0;
    if (state == INIT) begin
      if (rst_n) begin
        rf_write   = 1'b1;
        rf_rd_addr = init_ptr;
      end
    end else if (gnt != 2'b00) begin
      if (issue_we) begin
        rf_write   = addr_ok(32'(issue_a), NUM_REGS);
        rf_rd_addr = issue_a;
        rf_rd_in   = issue_wd;
      end else begin
        rf_read    = 1'b1;
        rf_rt_addr = issue_a;
        rf_rs_addr = issue_b;
      end
    end
  end

  // Stage p1: read data returns from the register file; route it to the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      owner_p1 <= CORE;
    end else begin
      vld_p1   <= rf_read;
      owner_p1 <= gnt[1] ? DEBUG : CORE;
    end
  end

  always_ff @(posedge clk) begin
    ok_a_p1 <= addr_ok(32'(issue_a), NUM_REGS);
    ok_b_p1 <= addr_ok(32'(issue_b), NUM_REGS);
  end

  assign lane_a = ok_a_p1 ? rf_rt_out : '0;
  assign lane_b = ok_b_p1 ? rf_rs_out : '0;

  assign c_rvalid  = vld_p1 && (owner_p1 == CORE);
  assign d_rvalid  = vld_p1 && (owner_p1 == DEBUG);
  assign c_rdata_a = c_rvalid ? lane_a : '0;
  assign c_rdata_b = c_rvalid ? lane_b : '0;
  assign d_rdata_a = d_rvalid ? lane_a : '0;
  assign d_rdata_b = d_rvalid ? lane_b : '0;

endmodule
